// File: rtl/alu_pkg.sv
// Shared constants, ALU op encodings and the buffered operand entry.
// OPSTAGE_SNOOP_EN adds source tags to each entry for write-back snooping.
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_CNT = 8;
    localparam int ADDR_W  = $clog2(REG_CNT);
    localparam int OP_W    = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASSB = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_NOTB  = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
`ifdef OPSTAGE_SNOOP_EN
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic              b_is_imm;
`endif
    } opstage_entry_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode, write-back and ALU-side signals of the operand stage.
// slave is the stage itself, master is whoever drives it.
interface alu_operand_stage_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs;
    logic [ADDR_W-1:0] in_rt;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_rd;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_rd;

    modport slave (
        input  in_valid, in_rs, in_rt, in_imm, in_use_imm, in_op, in_rd,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_rd
    );

    modport master (
        output in_valid, in_rs, in_rt, in_imm, in_use_imm, in_op, in_rd,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_rd
    );

endinterface

// File: rtl/opstage_skid_buffer.sv
// Two-entry FIFO of operand entries; slot0 is always the head.
// With OPSTAGE_SNOOP_EN, resident operands follow register write-back.
module opstage_skid_buffer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  opstage_entry_t    in_entry,
`ifdef OPSTAGE_SNOOP_EN
    input  logic              snoop_en,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic [DATA_W-1:0] snoop_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output opstage_entry_t    out_entry
);

    opstage_entry_t slot0, slot1;
    opstage_entry_t h0, h1;
    opstage_entry_t s0_n, s1_n;
    logic [1:0]     count, cnt_n;
    logic           push, pop;

`ifdef OPSTAGE_SNOOP_EN
    function automatic opstage_entry_t snoop(opstage_entry_t e);
        opstage_entry_t r;
        r = e;
        if (snoop_en && snoop_addr != '0) begin
            if (e.rs == snoop_addr) r.a = snoop_data;
            if (!e.b_is_imm && e.rt == snoop_addr) r.b = snoop_data;
        end
        return r;
    endfunction
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
`ifdef OPSTAGE_SNOOP_EN
        h0 = snoop(slot0);
        h1 = snoop(slot1);
`else
        h0 = slot0;
        h1 = slot1;
`endif
        s0_n  = h0;
        s1_n  = h1;
        cnt_n = count;
        case ({push, pop})
            2'b10: begin
                if (count == 2'd0) s0_n = in_entry;
                else               s1_n = in_entry;
                cnt_n = count + 2'd1;
            end
            2'b01: begin
                s0_n  = h1;
                cnt_n = count - 2'd1;
            end
            2'b11: begin
                // push needs !full and pop needs !empty, so count is 1 here
                s0_n = in_entry;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0     <= '0;
            slot1     <= '0;
            count     <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            slot0     <= s0_n;
            slot1     <= s1_n;
            count     <= cnt_n;
            in_ready  <= (cnt_n != 2'd2);
            out_valid <= (cnt_n != 2'd0);
        end
    end

    assign out_entry = slot0;

endmodule

// File: rtl/alu_operand_stage.sv
// Register file, operand select with write-back bypass, and skid buffer to the ALU.
// OPSTAGE_SNOOP_EN forwards write-back into entries already buffered.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_operand_stage_if.slave  bus
);

    logic [DATA_W-1:0] regs [REG_CNT];
    logic [DATA_W-1:0] a_val, b_val;
    opstage_entry_t    new_entry, head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != '0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // R0 is hardwired zero; a write landing this edge is forwarded
    always_comb begin
        a_val = regs[bus.in_rs];
        if (bus.in_rs == '0)
            a_val = '0;
        else if (bus.wb_en && bus.wb_addr == bus.in_rs)
            a_val = bus.wb_data;
        b_val = regs[bus.in_rt];
        if (bus.in_use_imm)
            b_val = bus.in_imm;
        else if (bus.in_rt == '0)
            b_val = '0;
        else if (bus.wb_en && bus.wb_addr == bus.in_rt)
            b_val = bus.wb_data;
    end

    always_comb begin
        new_entry    = '0;
        new_entry.a  = a_val;
        new_entry.b  = b_val;
        new_entry.op = bus.in_op;
        new_entry.rd = bus.in_rd;
`ifdef OPSTAGE_SNOOP_EN
        new_entry.rs       = bus.in_rs;
        new_entry.rt       = bus.in_rt;
        new_entry.b_is_imm = bus.in_use_imm;
`endif
    end

    opstage_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (bus.in_valid),
        .in_ready   (bus.in_ready),
        .in_entry   (new_entry),
`ifdef OPSTAGE_SNOOP_EN
        .snoop_en   (bus.wb_en),
        .snoop_addr (bus.wb_addr),
        .snoop_data (bus.wb_data),
`endif
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_entry  (head)
    );

    assign bus.out_a  = head.a;
    assign bus.out_b  = head.b;
    assign bus.out_op = head.op;
    assign bus.out_rd = head.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed bench for alu_operand_stage against a queue model.
// Honours OPSTAGE_SNOOP_EN the same way as the design.
module tb_alu_operand_stage;
    import alu_pkg::*;

    typedef struct {
        int unsigned a, b, op, rd, rs, rt;
        bit          imm;
    } ment_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int unsigned mregs [8];
    ment_t q [$];

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned mread(int unsigned src, bit we,
                                          int unsigned wa, int unsigned wd);
        if (src == 0) return 0;
        if (we && wa == src) return wd;
        return mregs[src];
    endfunction

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_imm = 0;
        bus.in_use_imm = 0; bus.in_op = 0; bus.in_rd = 0;
        bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.out_ready = 0;
    endtask

    // called at a falling edge; spans one rising edge, returns at the next fall
    task automatic step(input bit v, input int unsigned rs, input int unsigned rt,
                        input int unsigned imm, input bit ui, input int unsigned op,
                        input int unsigned rd, input bit we, input int unsigned wa,
                        input int unsigned wd, input bit ordy);
        ment_t e;
        bit push, pop;
        bus.in_valid = v; bus.in_rs = rs[2:0]; bus.in_rt = rt[2:0];
        bus.in_imm = imm[15:0]; bus.in_use_imm = ui; bus.in_op = op[2:0];
        bus.in_rd = rd[2:0]; bus.wb_en = we; bus.wb_addr = wa[2:0];
        bus.wb_data = wd[15:0]; bus.out_ready = ordy;
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        push = v && q.size() < 2;
        pop  = ordy && q.size() > 0;
        e.a = mread(rs, we, wa, wd);
        e.b = ui ? imm : mread(rt, we, wa, wd);
        e.op = op; e.rd = rd; e.rs = rs; e.rt = rt; e.imm = ui;
        @(posedge clk);
`ifdef OPSTAGE_SNOOP_EN
        if (we && wa != 0)
            foreach (q[i]) begin
                if (q[i].rs == wa) q[i].a = wd;
                if (!q[i].imm && q[i].rt == wa) q[i].b = wd;
            end
`endif
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (we && wa != 0) mregs[wa] = wd;
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_a", 32'(bus.out_a), q[0].a);
            chk("out_b", 32'(bus.out_b), q[0].b);
            chk("out_op", 32'(bus.out_op), q[0].op);
            chk("out_rd", 32'(bus.out_rd), q[0].rd);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (mregs[i]) mregs[i] = 0;
    endtask

    initial begin
        int unsigned snoop_exp;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
        chk("rst_a", 32'(bus.out_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // fill registers, queue two, then reset mid-stream
        for (int i = 1; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 1, i, 16'h1000 + i, 0);
        step(1, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 3, 4, 0, 0, 2, 2, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_a", 32'(bus.out_a), 0);
        chk("mid_rst_op", 32'(bus.out_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 1; i < 8; i++) step(1, i, i, 0, 0, 0, i, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // write then read with immediate B
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 16'h1234, 1);
        step(1, 3, 0, 16'h00FF, 1, 1, 4, 0, 0, 0, 0);
        chk("t2_a", 32'(bus.out_a), 16'h1234);
        chk("t2_b", 32'(bus.out_b), 16'h00FF);
        chk("t2_op", 32'(bus.out_op), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // same-cycle bypass, and R0 stays zero
        step(1, 5, 5, 0, 0, 2, 5, 1, 5, 16'hBEEF, 0);
        chk("t3_a", 32'(bus.out_a), 16'hBEEF);
        chk("t3_b", 32'(bus.out_b), 16'hBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 1);
        step(1, 0, 0, 0, 0, 3, 1, 1, 0, 16'hFFFF, 0);
        chk("t3_r0", 32'(bus.out_a), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // backpressure: third push refused until a pop frees a slot
        step(1, 1, 2, 16'h0011, 1, 1, 1, 0, 0, 0, 0);
        step(1, 2, 3, 16'h0022, 1, 2, 2, 0, 0, 0, 0);
        chk("t4_full", 32'(bus.in_ready), 0);
        step(1, 3, 4, 16'h0033, 1, 3, 3, 0, 0, 0, 0);
        step(1, 3, 4, 16'h0033, 1, 3, 3, 0, 0, 0, 1);
        chk("t4_ready_back", 32'(bus.in_ready), 1);
        chk("t4_head", 32'(bus.out_rd), 2);
        step(1, 3, 4, 16'h0033, 1, 3, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_order", 32'(bus.out_rd), 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // streaming with one resident entry
        step(1, 1, 0, 16'h0100, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, i % 8, 1, 16'h0200 + i, 1, i % 6, i % 8, 0, 0, 0, 1);
            chk("t5_rd", 32'(bus.out_rd), i % 8);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // stalled entry sees a later write to its source
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 16'h0001, 1);
        step(1, 2, 0, 16'h0009, 1, 1, 6, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 16'h0002, 0);
`ifdef OPSTAGE_SNOOP_EN
        snoop_exp = 2;
`else
        snoop_exp = 1;
`endif
        chk("t6_snoop", 32'(bus.out_a), snoop_exp);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
                 $urandom_range(0, 2) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
